shared_reg_arbiter: RTL

Round-robin write arbiter for a single shared W-bit register built from asynchronously-reset D flip-flops. Four requesters compete for write access. Per cycle, at most one requester is granted and its data is captured into the register. A requester can lock the register for a bounded burst of consecutive writes. The block sits between independent sequential units, such as counters and detectors, and a common status/data register that all of them update.

---
 rtl/shared_reg_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared W-bit register with four requesters.
// A requester may lock the register for a burst of at most LOCK_MAX consecutive cycles.
module shared_reg_arbiter #(
    parameter int unsigned W        = 8,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [3:0]     REQ,
    input  logic [3:0]     LOCK,
    input  logic [4*W-1:0] WDATA,
    output logic [3:0]     ACK,
    output logic [W-1:0]   Q,
    output logic [1:0]     LAST_ID,
    output logic           BUSY
);

    localparam int unsigned CntW = $clog2(LOCK_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    q_q;
    logic [1:0]      last_q;

    logic            found;
    logic [1:0]      sel;
    logic [1:0]      cand;
    logic            ack_vld;
    logic [1:0]      ack_id;

    // First requester at or after ptr_q, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        ack_vld = 1'b0;
        ack_id  = sel;
        if (!RESET) begin
            if (state_q == StOwned) begin
                ack_id  = owner_q;
                ack_vld = REQ[owner_q];
            end else begin
                ack_id  = sel;
                ack_vld = found;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    ptr_d = sel + 2'd1;
                    if (LOCK[sel]) begin
                        state_d = StOwned;
                        owner_d = sel;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StOwned: begin
                // Owned cycles count even when the owner drops REQ.
                if (!LOCK[owner_q] || cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q    <= '0;
            last_q <= 2'd0;
        end else if (ack_vld) begin
            q_q    <= WDATA[ack_id*W +: W];
            last_q <= ack_id;
        end
    end

    assign ACK     = ack_vld ? (4'b0001 << ack_id) : 4'b0000;
    assign Q       = q_q;
    assign LAST_ID = last_q;
    assign BUSY    = (state_q == StOwned);

endmodule
